// File: rtl/tile_engine_dbuf_if.sv
// tile_engine_dbuf_if: sequencer, tile/pattern RAM and pixel mixer signals of
// one tile layer. The master side is the surrounding PPU, the slave side is the engine.
interface tile_engine_dbuf_if;
  logic [7:0]  row;
  logic [17:0] scroll;
  logic        enable;
  logic        prep;
  logic        done;
  logic [10:0] tilram_addr;
  logic [63:0] tilram_rddata;
  logic [11:0] patram_addr;
  logic [63:0] patram_rddata;
  logic [8:0]  pixel_addr;
  logic [7:0]  pixel_data;

  modport master (
    output row, scroll, enable, prep, tilram_rddata, patram_rddata, pixel_addr,
    input  done, tilram_addr, patram_addr, pixel_data
  );

  modport slave (
    input  row, scroll, enable, prep, tilram_rddata, patram_rddata, pixel_addr,
    output done, tilram_addr, patram_addr, pixel_data
  );
endinterface

// File: rtl/tile_engine_dbuf.sv
// tile_engine_dbuf: renders one scanline of a 64x64-tile, 8x8-pixel, 4bpp
// layer into the back half of a double-buffered line buffer (3 cycles per
// tile) while the mixer reads pixels from the front half.
module tile_engine_dbuf #(
  parameter bit FG       = 1'b0,
  parameter int SCREEN_W = 320,
  parameter bit FLIP_EN  = 1'b1
) (
  input logic clk,
  input logic rst_n,
  tile_engine_dbuf_if.slave bus
);
  localparam int NT    = SCREEN_W / 8 + 1;
  localparam int KW    = $clog2(NT);
  localparam int SLOTB = NT * 8;
  localparam int AW    = $clog2(2 * SLOTB);
  localparam logic [8:0]    SCREEN_W9 = 9'(SCREEN_W);
  localparam logic [KW-1:0] K_LAST    = KW'(NT - 1);
  localparam logic [AW-1:0] BANK1     = AW'(SLOTB);

  typedef enum logic [2:0] {IDLE, TADDR, TDATA, PDATA, DONE} state_t;

  state_t        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [8:0]    y_q;
  logic [8:0]    scrollX_q;
  logic          enable_q;
  logic [3:0]    pal_q;
  logic          hflip_q;
  logic          fy0_q;
  logic          frontSel_q;
  logic [2:0]    frontFine_q;
  logic [7:0]    pixel_q;

  logic [7:0]    lineBuf [2*SLOTB];

  logic [5:0]    tx;
  logic [15:0]   entry;
  logic          vflipEff;
  logic [2:0]    fy;
  logic [31:0]   patRow;
  logic [AW-1:0] wrBase;
  logic [7:0]    wrByte [8];
  logic [AW-1:0] rdAddr;

  // Map column of the current tile: coarse scroll plus tile counter, wrapping at 64
  assign tx = scrollX_q[8:3] + 6'(k_q);

  // Select this tile's entry from the 4-entry RAM word and derive the fine row inside the tile
  always_comb begin
    entry    = bus.tilram_rddata[16*tx[1:0] +: 16];
    vflipEff = entry[15] & FLIP_EN;
    fy       = y_q[2:0] ^ {3{vflipEff}};
  end

  assign bus.tilram_addr = (state_q == TADDR) ? {FG, y_q[8:3], tx[5:2]} : 11'h000;
  assign bus.patram_addr = (state_q == TDATA) ? {entry[9:0], fy[2:1]} : 12'h000;
  assign bus.done        = (state_q == DONE);
  assign bus.pixel_data  = pixel_q;

  // State and tile counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // Next state: TADDR -> TDATA -> PDATA per tile, DONE after the last slot
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (bus.prep) begin
          state_d = TADDR;
          k_d     = '0;
        end
      end
      TADDR: state_d = TDATA;
      TDATA: state_d = PDATA;
      PDATA: begin
        if (k_q == K_LAST) begin
          state_d = DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = TADDR;
        end
      end
      DONE: begin
        k_d     = '0;
        state_d = IDLE;
      end
      default: begin
        k_d     = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Latch line parameters on an accepted prep, tile attributes in TDATA, and swap buffers in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q         <= '0;
      scrollX_q   <= '0;
      enable_q    <= 1'b0;
      pal_q       <= '0;
      hflip_q     <= 1'b0;
      fy0_q       <= 1'b0;
      frontSel_q  <= 1'b0;
      frontFine_q <= '0;
    end else begin
      if (state_q == IDLE && bus.prep) begin
        y_q       <= {1'b0, bus.row} + bus.scroll[17:9];
        scrollX_q <= bus.scroll[8:0];
        enable_q  <= bus.enable;
      end
      if (state_q == TDATA) begin
        pal_q   <= entry[13:10];
        hflip_q <= entry[14] & FLIP_EN;
        fy0_q   <= fy[0];
      end
      if (state_q == DONE) begin
        frontSel_q  <= ~frontSel_q;
        frontFine_q <= scrollX_q[2:0];
      end
    end
  end

  // Build the 8 output bytes of the current tile for its slot in the back buffer
  always_comb begin
    wrBase = (frontSel_q ? '0 : BANK1) + AW'({k_q, 3'b000});
    patRow = fy0_q ? bus.patram_rddata[63:32] : bus.patram_rddata[31:0];
    for (int p = 0; p < 8; p++) begin
      wrByte[p] = enable_q ? {pal_q, patRow[4*(3'(p) ^ {3{hflip_q}}) +: 4]} : 8'h00;
    end
  end

  // Line buffer storage: one 8-byte slot written per PDATA cycle
  always_ff @(posedge clk) begin
    if (state_q == PDATA) begin
      for (int p = 0; p < 8; p++) begin
        lineBuf[wrBase + AW'(p)] <= wrByte[p];
      end
    end
  end

  // Front-buffer address: screen x shifted by the fine scroll the front line was rendered with
  always_comb begin
    rdAddr = '0;
    if (bus.pixel_addr < SCREEN_W9) begin
      rdAddr = (frontSel_q ? BANK1 : '0) + AW'(bus.pixel_addr) + AW'(frontFine_q);
    end
  end

  // Registered pixel output; off-screen addresses read as transparent zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_q <= 8'h00;
    end else begin
      pixel_q <= (bus.pixel_addr < SCREEN_W9) ? lineBuf[rdAddr] : 8'h00;
    end
  end
endmodule
